// File: rtl/cla_mp_add_ctrl.sv
// Multi-precision add/subtract sequencer around a single 6-bit carry-lookahead adder.
// One limb is processed per cycle, LSB limb first; the limb carry is registered between cycles.
// Optional feature macro: CLA_MP_SUB_EN enables subtraction (a - b).
// With the macro undefined, the sub input is ignored.
module cla_mp_add_ctrl #(
  parameter int unsigned LIMBS = 4,
  localparam int unsigned W    = 6 * LIMBS,
  localparam int unsigned IdxW = (LIMBS > 1) ? $clog2(LIMBS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            c_out_q, c_out_d, ovf_q, ovf_d;

  logic            sub_new;  // effective subtract flag to latch on start
  logic            sub_eff;  // effective subtract flag of the running operation
  logic [5:0]      a_limb, b_limb, add_sum, g, p;
  logic [6:0]      cc;
  logic            add_co, b_msb_eff, last;

`ifdef CLA_MP_SUB_EN
  logic sub_q, sub_d;

  // Subtract flag register, loaded on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end

  // Latch sub only when a new operation is accepted.
  always_comb begin
    sub_new = sub;
    sub_eff = sub_q;
    sub_d   = sub_q;
    if (start && (state_q != StRun)) sub_d = sub;
  end

  // Subtract feeds the inverted B limb; the +1 comes from the initial carry.
  always_comb begin
    a_limb    = a_q[idx_q*6 +: 6];
    b_limb    = b_q[idx_q*6 +: 6] ^ {6{sub_eff}};
    b_msb_eff = b_q[W-1] ^ sub_eff;
  end
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_new    = 1'b0;
  assign sub_eff    = 1'b0;

  // Add-only build: B limb goes to the adder unmodified.
  always_comb begin
    a_limb    = a_q[idx_q*6 +: 6];
    b_limb    = b_q[idx_q*6 +: 6];
    b_msb_eff = b_q[W-1];
  end
`endif

  // 6-bit carry-lookahead adder: each carry is a flat sum of generate/propagate products.
  always_comb begin
    logic cy;
    logic term;
    g     = a_limb & b_limb;
    p     = a_limb ^ b_limb;
    cc    = '0;
    cc[0] = carry_q;
    cy    = 1'b0;
    term  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      term = carry_q;
      for (int k = 0; k <= i; k++) term = term & p[k];
      cy = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        cy = cy | term;
      end
      cc[i+1] = cy;
    end
    add_sum = p ^ cc[5:0];
    add_co  = cc[6];
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign last = (idx_q == IdxW'(LIMBS - 1));

  // Next-state: accept start in IDLE/DONE, step one limb per cycle in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = sub_new;
          sum_d   = '0;
          c_out_d = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[idx_q*6 +: 6] = add_sum;
        carry_d             = add_co;
        idx_d               = idx_q + 1'b1;
        if (last) begin
          state_d = StDone;
          c_out_d = add_co;
          ovf_d   = (a_q[W-1] == b_msb_eff) && (add_sum[5] != a_q[W-1]);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_cla_mp_add_ctrl.sv
// Self-checking bench for cla_mp_add_ctrl with LIMBS=4 (24-bit operands).
// Honours CLA_MP_SUB_EN the same way as the design build.
module tb_cla_mp_add_ctrl;

  localparam int unsigned L = 4;
  localparam int unsigned W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, c_out, ovf;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_err    = 0;

  cla_mp_add_ctrl #(.LIMBS(L)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         c;
    logic         o;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on full-width operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] rs, output logic rc, output logic ro);
    longint ua, ub, ur;
    longint sa, sb, sr;
    logic   eff;
`ifdef CLA_MP_SUB_EN
    eff = ms;
`else
    eff = 1'b0;
`endif
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (eff) begin
      ur = ua - ub;
      rc = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      rc = (ur >= 64'sd16777216);
      sr = sa + sb;
    end
    rs = ur[W-1:0];
    ro = (sr > 64'sd8388607) || (sr < -64'sd8388608);
  endtask

  // Issue one operation at a negedge and wait (bounded) for done.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        output int busy_cnt, output bit got_done);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    sub   = ts;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
    chk("done_seen", 32'(got_done), 32'd1);
  endtask

  initial begin
    int           bc, cnt, ndone;
    bit           gd;
    logic [W-1:0] es, held;
    logic         ec, eo;

    vecs[0] = '{"carry_6",    24'h000FFF, 24'h000001, 1'b0, 24'h001000, 1'b0, 1'b0};
    vecs[1] = '{"ripple_all", 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b0};
    vecs[2] = '{"pos_ovf",    24'h7FFFFF, 24'h000001, 1'b0, 24'h800000, 1'b0, 1'b1};
    vecs[3] = '{"neg_ovf",    24'h800000, 24'h800000, 1'b0, 24'h000000, 1'b1, 1'b1};
`ifdef CLA_MP_SUB_EN
    vecs[4] = '{"sub_5_7",    24'h000005, 24'h000007, 1'b1, 24'hFFFFFE, 1'b0, 1'b0};
`else
    vecs[4] = '{"sub_ignored", 24'h000005, 24'h000007, 1'b1, 24'h00000C, 1'b0, 1'b0};
`endif

    // Reset values
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, bc, gd);
      chk({vecs[i].name, "_busy_cycles"}, 32'(bc), 32'd4);
      chk({vecs[i].name, "_sum"}, 32'(sum), 32'(vecs[i].sum));
      chk({vecs[i].name, "_cout"}, 32'(c_out), 32'(vecs[i].c));
      chk({vecs[i].name, "_ovf"}, 32'(ovf), 32'(vecs[i].o));
      @(negedge clk);
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
      chk({vecs[i].name, "_sum_hold"}, 32'(sum), 32'(vecs[i].sum));
    end

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb = ~ra;
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, es, ec, eo);
      run_op(ra, rb, rs, bc, gd);
      chk("rand_sum", 32'(sum), 32'(es));
      chk("rand_cout", 32'(c_out), 32'(ec));
      chk("rand_ovf", 32'(ovf), 32'(eo));
    end

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a = 24'h123456; b = 24'h111111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(c_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Start pulsed during RUN is ignored
    @(negedge clk);
    a = 24'h000123; b = 24'h000456; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 24'h0F0F0F; b = 24'h010101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    held  = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        held = sum;
      end
      @(negedge clk);
    end
    chk("ignore_done_count", 32'(ndone), 32'd1);
    chk("ignore_sum", 32'(held), 32'h000579);

    // Start held across DONE: back-to-back operations
    @(negedge clk);
    a = 24'h000001; b = 24'h000002; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 24'h000010; b = 24'h000020;
    cnt = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first_done", 32'(done), 32'd1);
    chk("b2b_first_sum", 32'(sum), 32'h000003);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    cnt = 1;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_gap", 32'(cnt), 32'd5);
    chk("b2b_second_sum", 32'(sum), 32'h000030);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_mp_add_ctrl.md
# cla_mp_add_ctrl

Multi-precision add/subtract sequencer built around one 6-bit carry-lookahead adder (`cla_adder_6b`). It runs the adder once per cycle, least-significant 6-bit limb first, and registers each carry for the next limb, so a single adder serves operands of any width. It sits between a requester using a start/done handshake and the shared adder.

## Interface
- `LIMBS`, default 4: number of 6-bit limbs; operand width W = 6*LIMBS; minimum 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `sub`  in  1  1 = compute a-b; 0 = compute a+b; latched with `start`.
- `a`  in  W  operand A; latched with `start`.
- `b`  in  W  operand B; latched with `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `sum`  out  W  result register.
- `c_out`  out  1  carry out of the top limb. For subtract, 1 means no borrow.
- `ovf`  out  1  two's-complement signed overflow of the full-width result.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: steps limb index `idx` from 0 to LIMBS-1.
  - DONE: one cycle; `done`=1.
- IDLE or DONE with `start`=1 -> RUN, on the same edge:
  - latch `a` and `b`;
  - latch effective `sub` (s);
  - `idx`<=0, `carry`<=s;
  - clear `sum`, `c_out` and `ovf`.
- IDLE or DONE with `start`=0: DONE -> IDLE; IDLE holds.
- RUN, each cycle, adder inputs:
  - a_limb = A[6*idx+5:6*idx];
  - b_limb = B[6*idx+5:6*idx] XOR {6{s}};
  - c_in = `carry`.
- RUN, at the edge:
  - write the adder sum into the `sum` limb `idx`;
  - `carry`<=adder c_out;
  - `idx`<=idx+1.
- At `idx`=LIMBS-1 the edge also does the following and moves to DONE:
  - `c_out`<=adder c_out;
  - `ovf`<=(a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff_msb is the inverted MSB for subtract.
- `start` during RUN is ignored; no queueing.
- `sum`, `c_out` and `ovf` hold from DONE until the next accepted `start`.
- Width rules:
  - `idx` is ceil(log2(LIMBS)) bits, minimum 1 bit.
  - Results are modulo 2^W; no saturation.

## Timing
- Reset values: state IDLE; `busy`, `done`, `c_out`, `ovf`, `idx` and `carry` = 0; `sum`=0.
- Reset is asynchronous. Asserting `rst` mid-RUN aborts the operation and restores reset values immediately. No partial result is retained.
- Latency, with `start` accepted at edge E0:
  - `busy`=1 from E0 to E_LIMBS;
  - limb k is written at edge E(k+1);
  - `done`=1 for the cycle after E_LIMBS;
  - total: LIMBS+1 cycles from start to `done`.
- Back-to-back: `start` held during DONE begins the next operation at that edge. Throughput is one result per LIMBS+1 cycles.
- LIMBS=1: RUN lasts exactly one cycle.

## Configuration
- `CLA_MP_SUB_EN` defined:
  - subtract supported as specified;
  - s = latched `sub`.
- `CLA_MP_SUB_EN` undefined:
  - `sub` port remains but is ignored; s is forced to 0;
  - no B-inversion logic; initial carry is 0;
  - `ovf` uses the raw `b` MSB.

## Test plan
All cases use LIMBS=4.
1. a=0x000FFF, b=0x000001, sub=0, start at E0 -> `done` after E4; sum=0x001000, c_out=0, ovf=0; `busy` high for exactly 4 cycles.
2. a=0xFFFFFF, b=0x000001, sub=0 -> sum=0x000000, c_out=1, ovf=0. Exercises the carry ripple through every limb.
3. a=0x7FFFFF, b=0x000001, sub=0 -> sum=0x800000, c_out=0, ovf=1. Then a=0x800000, b=0x800000 -> sum=0, c_out=1, ovf=1.
4. a=0x000005, b=0x000007, sub=1, with macro -> sum=0xFFFFFE, c_out=0, ovf=0. Without macro -> sum=0x00000C, c_out=0.
5. Start an add, assert `rst` after E2 -> `busy`, `done`, `sum`, `c_out` and `ovf` all 0 immediately. Next, a second `start` pulsed during RUN is ignored: exactly one `done`, carrying the first operation's result.
6. `start` held high across DONE with new operands a=0x000010, b=0x000020 -> first result is visible in DONE, then the second operation begins at that edge; second `done` follows 5 cycles later with sum=0x000030.
